// File: rtl/serial_host.sv
// serial_host: host-side initiator for the board UART command protocol.
// Expands one parallel command into acked command/data bytes.
module serial_host #(
   parameter int ACK_TIMEOUT = 65536
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [23:0] cmd_addr,
   input  logic [7:0]  cmd_red,
   input  logic [7:0]  cmd_green,
   input  logic [7:0]  cmd_blue,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [1:0]  mode,
   output logic        tx_start,
   output logic [7:0]  tx_byte,
   input  logic        tx_busy,
   input  logic        rx_valid,
   input  logic [7:0]  rx_byte
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

   localparam logic [1:0] OP_WRITE = 2'd0;
   localparam logic [1:0] OP_VIDEO = 2'd1;
   localparam logic [1:0] OP_CLOSE = 2'd2;

   localparam logic [1:0] M_IDLE = 2'd0;
   localparam logic [1:0] M_CON  = 2'd1;
   localparam logic [1:0] M_VID  = 2'd2;
   localparam logic [1:0] M_RAM  = 2'd3;

   localparam logic [1:0] E_NONE    = 2'd0;
   localparam logic [1:0] E_TIMEOUT = 2'd1;
   localparam logic [1:0] E_BADACK  = 2'd2;
   localparam logic [1:0] E_BADOP   = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAN,
      S_SEND,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_t;

   // Each step is {send byte, expected ack}; the longest plan has 11.
   // Steps are pushed in at index 0, so the first step sits at n-1.
   typedef logic [10:0][15:0] plan_t;

   state_t         state_q, state_d;
   logic [1:0]     op_q, op_d;
   logic [23:0]    addr_q, addr_d;
   logic [7:0]     red_q, red_d;
   logic [7:0]     green_q, green_d;
   logic [7:0]     blue_q, blue_d;
   plan_t          plan_q, plan_d;
   logic [3:0]     idx_q, idx_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic           tx_start_q, tx_start_d;
   logic [7:0]     tx_byte_q, tx_byte_d;
   logic [1:0]     err_code_q, err_code_d;
   logic [1:0]     mode_q, mode_d;

   plan_t          plan_c;
   logic [3:0]     plan_n;
   logic [7:0]     exp_ack;
   logic [7:0]     send_byte;

   function automatic void push(
      inout plan_t      p,
      inout logic [3:0] n,
      input logic [15:0] step
   );
      p = {p[9:0], step};
      n = n + 4'd1;
   endfunction

   function automatic logic [1:0] ack_mode(
      input logic [7:0] ack,
      input logic [1:0] cur
   );
      logic [1:0] m;
      case (ack)
         8'h01:   m = M_CON;
         8'h02:   m = M_VID;
         8'h03:   m = M_RAM;
         8'h04:   m = M_IDLE;
         default: m = cur;
      endcase
      return m;
   endfunction

   assign exp_ack   = plan_q[idx_q][7:0];
   assign send_byte = plan_q[idx_q][15:8];

   // Compose the step list for the latched command from the current mode.
   always_comb begin
      plan_c = '0;
      plan_n = '0;
      case (op_q)
         OP_WRITE: begin
            if (mode_q == M_VID) begin
               push(plan_c, plan_n, 16'hA004);
            end
            if (mode_q != M_RAM) begin
               push(plan_c, plan_n, 16'hAA01);
               push(plan_c, plan_n, 16'hAC03);
            end
            push(plan_c, plan_n, 16'hAFAF);
            push(plan_c, plan_n, {addr_q[7:0], 8'h10});
            push(plan_c, plan_n, {addr_q[15:8], 8'h11});
            push(plan_c, plan_n, {addr_q[23:16], 8'h12});
            push(plan_c, plan_n, {red_q, 8'h13});
            push(plan_c, plan_n, {green_q, 8'h14});
            push(plan_c, plan_n, {blue_q, 8'h15});
            push(plan_c, plan_n, 16'hA1A1);
         end
         OP_VIDEO: begin
            if (mode_q == M_RAM) begin
               push(plan_c, plan_n, 16'hAD04);
            end
            if (mode_q != M_VID) begin
               push(plan_c, plan_n, 16'hAA01);
               push(plan_c, plan_n, 16'hAB02);
            end
         end
         OP_CLOSE: begin
            if (mode_q == M_RAM) begin
               push(plan_c, plan_n, 16'hAD04);
            end else if (mode_q == M_VID) begin
               push(plan_c, plan_n, 16'hA004);
            end
         end
         default: ;
      endcase
   end

   // Next-state, datapath updates and status outputs.
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      addr_d     = addr_q;
      red_d      = red_q;
      green_d    = green_q;
      blue_d     = blue_q;
      plan_d     = plan_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q;
      tx_start_d = 1'b0;
      tx_byte_d  = tx_byte_q;
      err_code_d = err_code_q;
      mode_d     = mode_q;
      cmd_ready  = 1'b0;
      done       = 1'b0;
      err        = 1'b0;

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            cmd_ready = 1'b1;
            done      = (state_q == S_DONE);
            err       = (state_q == S_ERR);
            state_d   = S_IDLE;
            if (cmd_valid) begin
               op_d       = cmd_op;
               addr_d     = cmd_addr;
               red_d      = cmd_red;
               green_d    = cmd_green;
               blue_d     = cmd_blue;
               err_code_d = E_NONE;
               state_d    = S_PLAN;
            end
         end
         S_PLAN: begin
            plan_d = plan_c;
            idx_d  = plan_n - 4'd1;
            if (op_q == 2'd3) begin
               err_code_d = E_BADOP;
               state_d    = S_ERR;
            end else if (plan_n == 4'd0) begin
               state_d = S_DONE;
            end else begin
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (!tx_busy) begin
               tx_start_d = 1'b1;
               tx_byte_d  = send_byte;
               cnt_d      = '0;
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            // A byte arriving on the last allowed cycle still counts.
            if (rx_valid) begin
               if (rx_byte == exp_ack) begin
                  mode_d = ack_mode(exp_ack, mode_q);
                  if (idx_q == 4'd0) begin
                     state_d = S_DONE;
                  end else begin
                     idx_d   = idx_q - 4'd1;
                     state_d = S_SEND;
                  end
               end else begin
                  err_code_d = E_BADACK;
                  mode_d     = M_IDLE;
                  state_d    = S_ERR;
               end
            end else if (cnt_q == CNT_LAST) begin
               err_code_d = E_TIMEOUT;
               mode_d     = M_IDLE;
               state_d    = S_ERR;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers; reset drops any command in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_q       <= '0;
         addr_q     <= '0;
         red_q      <= '0;
         green_q    <= '0;
         blue_q     <= '0;
         plan_q     <= '0;
         idx_q      <= '0;
         cnt_q      <= '0;
         tx_start_q <= 1'b0;
         tx_byte_q  <= '0;
         err_code_q <= E_NONE;
         mode_q     <= M_IDLE;
      end else begin
         op_q       <= op_d;
         addr_q     <= addr_d;
         red_q      <= red_d;
         green_q    <= green_d;
         blue_q     <= blue_d;
         plan_q     <= plan_d;
         idx_q      <= idx_d;
         cnt_q      <= cnt_d;
         tx_start_q <= tx_start_d;
         tx_byte_q  <= tx_byte_d;
         err_code_q <= err_code_d;
         mode_q     <= mode_d;
      end
   end

   assign tx_start = tx_start_q;
   assign tx_byte  = tx_byte_q;
   assign err_code = err_code_q;
   assign mode     = mode_q;

endmodule

// File: doc/serial_host.md
# serial_host

Host-side initiator for the board's UART command protocol. It turns one parallel command (pixel write, video on, close) into the command/data byte sequence the FPGA serial slave expects. Each byte is sent through an existing byte-level UART TX core, and the slave's acknowledge byte is checked through an existing UART RX core before the next byte goes out. It sits between a test/controller master and the UART cores, and is used board-to-board and as the stimulus driver in system benches.

## Interface
- ACK_TIMEOUT, 65536: cycles allowed between tx_start and matching ack; minimum 2.
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle, command accepted on cmd_valid & cmd_ready.
- cmd_op  in  2  0 WRITE_PIXEL, 1 VIDEO_ON, 2 CLOSE, 3 reserved.
- cmd_addr  in  24  pixel address (WRITE_PIXEL only).
- cmd_red, cmd_green, cmd_blue  in  8 each  pixel colour (WRITE_PIXEL only).
- done  out  1  one-cycle pulse, command completed.
- err  out  1  one-cycle pulse, command aborted.
- err_code  out  2  0 none, 1 ack timeout, 2 wrong ack, 3 reserved op; held until next accepted command.
- mode  out  2  tracked slave state: 0 IDLE, 1 CON, 2 VID, 3 RAM.
- tx_start  out  1  one-cycle byte-send strobe to TX core.
- tx_byte  out  8  byte to send, valid with tx_start.
- tx_busy  in  1  TX core transmitting.
- rx_valid  in  1  one-cycle strobe, byte received.
- rx_byte  in  8  received byte.

## Operation
- Operands are latched on acceptance. Each command expands to a list of (send byte / expected ack) steps, composed from the current mode:
- WRITE_PIXEL:
  - prefix A0/04 if mode=VID;
  - prefix AA/01, AC/03 if mode≠RAM;
  - then AF/AF, addr[7:0]/10, addr[15:8]/11, addr[23:16]/12, R/13, G/14, B/15, A1/A1.
- VIDEO_ON:
  - if mode=RAM: AD/04, AA/01, AB/02;
  - if mode=VID: no bytes;
  - else: AA/01, AB/02.
- CLOSE:
  - RAM: AD/04;
  - VID: A0/04;
  - IDLE/CON: no bytes.
- Op 3: no bytes, err with err_code=3.
- State machine:
  - IDLE: cmd_ready=1. Accept → PLAN.
  - PLAN: selects the first step; zero-step commands → DONE.
  - SEND: waits for tx_busy=0, then drives tx_start=1 and tx_byte for one cycle → WAIT.
  - WAIT: on rx_valid, if rx_byte=expected, go to the next step (SEND) or DONE; otherwise ERR.
  - DONE/ERR: pulse the output for one cycle → IDLE.
- Mode update on each matching ack: 01→CON, 02→VID, 03→RAM, 04→IDLE; others leave mode unchanged.
- On any error (code 1 or 2), mode:=IDLE. The slave state is then unknown, so the controller must reset the link.
- rx_valid outside WAIT is ignored; stray bytes never advance a step.
- cmd_valid while cmd_ready=0 is ignored (not queued).

## Timing
- Reset values: cmd_ready=1, tx_start=0, tx_byte=00, done=0, err=0, err_code=0, mode=0. All state is cleared, and the timeout counter is 0.
- Reset mid-command aborts the command: tx_start is 0 from the next edge, and no done/err is produced.
- Acceptance edge → cmd_ready=0 next cycle. First tx_start comes no earlier than 2 cycles after acceptance (PLAN then SEND), and later if tx_busy=1.
- tx_start is high for exactly one cycle per byte. A new tx_start is never issued before the previous byte's ack has matched.
- Ack match at edge N → next tx_start at N+1 at the earliest (tx_busy=0).
- Final ack at edge N → done=1 and cmd_ready=1 in cycle N+1. A new command may be accepted in that same cycle.
- Zero-step commands produce done 2 cycles after acceptance.
- Timeout counter: cleared on tx_start, increments each WAIT cycle. Reaching ACK_TIMEOUT without rx_valid → ERR, err_code=1.
  - rx_valid in the same cycle the counter reaches ACK_TIMEOUT is evaluated as an ack (ack wins).
- Mismatched ack → err pulse the next cycle; err_code=2.

## Test plan
- After reset: WRITE_PIXEL, addr=123456, RGB=11/22/33, with a model slave acking correctly → TX bytes AA AC AF 56 34 12 11 22 33 A1, one done pulse, mode=3.
- Second WRITE_PIXEL (addr=000001, RGB=FF/00/80) while mode=3 → only AF 01 00 00 FF 00 80 A1; done; mode stays 3.
- VIDEO_ON from RAM → AD AA AB, mode=2. Then CLOSE → A0, mode=0. Then CLOSE again → no bytes, done 2 cycles after acceptance.
- Slave answers 05 instead of AF → err pulse, err_code=2, mode=0, cmd_ready=1, no further tx_start.
- ACK_TIMEOUT=100, slave silent after AA → err with code 1 exactly 100 cycles after tx_start. Repeat with ack 01 arriving on cycle 100 → accepted, AC sent.
- Reset asserted after the addr[15:8] byte is sent → all outputs at reset values next cycle. A late ack 11 is then ignored, and a fresh WRITE_PIXEL restarts from the AA prefix.
